cdc_mem_noc: RTL and testbench
==============================

CDC_MEM_NOC -- requirements
Module: cdc_mem_noc

Interface
- REQ-001: Parameter DEPTH, default 4, sets FIFO entries; SHALL be a power of two, >= 2.
- REQ-002: Request payload type SHALL be mem_req_t from urv_typedef (includes field req_addr); width W = $bits(mem_req_t).
- REQ-003: src_clk  input  1  single clock for all logic.
- REQ-004: src_rstn  input  1  reset, asynchronous, active-low.
- REQ-005: src_req_valid  input  1  upstream request valid.
- REQ-006: src_req_ready  output  1  block can accept a request.
- REQ-007: src_req  input  W  upstream request payload.
- REQ-008: dest_req_valid  output  1  downstream request valid.
- REQ-009: dest_req_ready  input  1  downstream accepts request.
- REQ-010: dest_req  output  W  downstream request payload.

Function
- REQ-011: Block SHALL be a synchronous DEPTH-entry FIFO buffer between the src and dest valid/ready ports; there is one clock, src_clk, and no dest_clk or dest_rstn.
- REQ-012: Push SHALL occur on a src_clk rising edge when src_req_valid && src_req_ready; src_req is written at the write pointer.
- REQ-013: Pop SHALL occur on a src_clk rising edge when dest_req_valid && dest_req_ready.
- REQ-014: Read/write pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; empty = pointers equal; full = index bits equal and MSBs differ.
- REQ-015: src_req_ready SHALL be !full, registered-state only; it SHALL NOT depend on dest_req_ready in the same cycle.
- REQ-016: dest_req_valid SHALL be !empty; dest_req SHALL be the head entry while valid and all-zero while not valid.
- REQ-017: Latency (default build): request pushed at edge N SHALL appear on dest_req_valid/dest_req after edge N; minimum one cycle.
- REQ-018: Simultaneous push and pop SHALL keep occupancy unchanged and advance both pointers.
- REQ-019: When full, no push SHALL occur even if a pop happens in the same cycle.
- REQ-020: Ordering SHALL be strict FIFO; no request SHALL be dropped or duplicated.
- REQ-021: src_req SHALL be sampled only on an accepted push; changes while not accepted have no effect.

Reset
- REQ-022: While src_rstn = 0: pointers = 0, dest_req_valid = 0, dest_req = 0, src_req_ready = 0.
- REQ-023: The first rising src_clk edge after src_rstn deasserts SHALL leave src_req_ready = 1.
- REQ-024: Storage array SHALL NOT be reset.
- REQ-025: Reset asserted mid-operation SHALL discard all stored requests immediately and asynchronously.

Configuration
- REQ-026: Macro CDC_MEM_NOC_BYPASS_EN: when defined and the FIFO is empty, dest_req_valid = src_req_valid and dest_req = src_req combinationally.
- REQ-027: In that bypass case, when dest_req_ready = 1 the request SHALL NOT be written into the FIFO.
- REQ-028: In that bypass case, when dest_req_ready = 0 the request SHALL be pushed normally.
- REQ-029: When CDC_MEM_NOC_BYPASS_EN is undefined, no combinational path SHALL exist from src to dest ports, and latency SHALL follow REQ-017.

Verification
- REQ-030: Stream: with dest_req_ready = 1, push req_addr 0x1..0xF back-to-back -> dest_req.req_addr shows 0x1..0xF in order, one per cycle after the first-cycle latency; src_req_ready stays 1.
- REQ-031: Fill: with dest_req_ready = 0, push 0xA,0xB,0xC,0xD -> src_req_ready = 0 after the 4th push; a 5th value 0xE held is not accepted.
- REQ-032: Drain: from full, raise dest_req_ready -> outputs 0xA..0xD in order; src_req_ready returns to 1 the cycle after the first pop; 0xE is then accepted and emitted fifth.
- REQ-033: Concurrent: with occupancy 2, push and pop in the same cycle -> occupancy stays 2 and order is preserved.
- REQ-034: Reset: with 3 entries stored, pulse src_rstn low -> dest_req_valid = 0 immediately; after release the FIFO is empty.
- REQ-035: Bypass (macro defined): FIFO empty, dest_req_ready = 1, push 0x5 -> dest_req.req_addr = 0x5 in the same cycle and occupancy stays 0.

Source files
------------

// File: rtl/cdc_mem_noc.sv
// cdc_mem_noc: single-clock DEPTH-entry valid/ready request FIFO.
// Carries urv_typedef::mem_req_t from the src port to the dest port in
// strict order. src_req_ready comes from registered state only, so there is
// never a ready-to-ready combinational loop through this block.
// Optional build macro CDC_MEM_NOC_BYPASS_EN: while the FIFO is empty a
// request is forwarded combinationally to dest. If dest takes it in that
// cycle, it is never written into storage.

package urv_typedef;

    // Memory request carried through the FIFO.
    typedef struct packed {
        logic [31:0] req_addr;
        logic [31:0] req_wdata;
        logic [3:0]  req_be;
        logic        req_we;
    } mem_req_t;

endpackage

module cdc_mem_noc
    import urv_typedef::*;
#(
    // Number of entries; must be a power of two and at least 2.
    parameter int DEPTH = 4
) (
    input  logic     src_clk,
    input  logic     src_rstn,
    input  logic     src_req_valid,
    output logic     src_req_ready,
    input  mem_req_t src_req,
    output logic     dest_req_valid,
    input  logic     dest_req_ready,
    output mem_req_t dest_req
);

    // Index width, plus one wrap bit that separates full from empty.
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          live;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    mem_req_t      mem [DEPTH];
    mem_req_t      head;

    // Pointer comparison: equal means empty; same index with a different
    // wrap bit means full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign head  = mem[rd_ptr[AW-1:0]];

    // src_req_ready uses only registered state. 'live' holds ready low
    // during reset and through the first edge after reset is released.
    assign src_req_ready = live && !full;

    // A pop needs a real stored entry. Bypassed requests are not in storage.
    assign pop = !empty && dest_req_ready;

`ifdef CDC_MEM_NOC_BYPASS_EN
    // When empty, the src request is offered to dest directly. It goes into
    // storage only if dest refuses it in this cycle.
    assign push = src_req_valid && src_req_ready && !(empty && dest_req_ready);

    // Output selection with bypass: head entry when occupied, forwarded
    // request when empty, zeros otherwise.
    // NOTE: every output of this always_comb gets a default first, so no
    // path can leave a value unassigned and infer a latch.
    always_comb begin
        dest_req_valid = 1'b0;
        dest_req       = '0;
        if (!empty) begin
            dest_req_valid = 1'b1;
            dest_req       = head;
        end else if (live && src_req_valid) begin
            dest_req_valid = 1'b1;
            dest_req       = src_req;
        end
    end
`else
    assign push = src_req_valid && src_req_ready;

    // Output selection: head entry while occupied, zeros while empty. There
    // is no path from the src ports, so a request appears at the earliest
    // one edge after it is pushed.
    always_comb begin
        dest_req_valid = 1'b0;
        dest_req       = '0;
        if (!empty) begin
            dest_req_valid = 1'b1;
            dest_req       = head;
        end
    end
`endif

    // Readiness flag: cleared asynchronously, set by the first clock edge.
    // NOTE: sequential state uses non-blocking assignments only, so all
    // registers update together at the edge whatever the statement order.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            live <= 1'b0;
        end else begin
            live <= 1'b1;
        end
    end

    // Write pointer moves on each accepted push. The extra bit wraps the
    // pointer modulo 2*DEPTH.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
        end
    end

    // Read pointer moves on each pop. Asserting reset empties the FIFO at
    // once, which also drops dest_req_valid at once.
    always_ff @(posedge src_clk or negedge src_rstn) begin
        if (!src_rstn) begin
            rd_ptr <= '0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write at the write index. src_req is sampled only on a push.
    // NOTE: the array has no reset. The pointers alone decide which entries
    // are valid, and leaving reset off lets the array map onto plain RAM.
    always_ff @(posedge src_clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= src_req;
        end
    end

endmodule

// File: tb/tb_cdc_mem_noc.sv
// tb_cdc_mem_noc: self-checking bench for cdc_mem_noc (default build).
// A queue-based reference model holds the expected contents. Every cycle the
// bench checks ready, valid and payload against that model, before the edge.

module tb_cdc_mem_noc;
    import urv_typedef::*;

    localparam int DEPTH = 4;

    logic     src_clk;
    logic     src_rstn;
    logic     src_req_valid;
    logic     src_req_ready;
    mem_req_t src_req;
    logic     dest_req_valid;
    logic     dest_req_ready;
    mem_req_t dest_req;

    int tests = 0;
    int fails = 0;

    // Reference model state
    mem_req_t model_q[$];
    bit       model_live;
    bit       last_push;

    cdc_mem_noc #(.DEPTH(DEPTH)) dut (
        .src_clk       (src_clk),
        .src_rstn      (src_rstn),
        .src_req_valid (src_req_valid),
        .src_req_ready (src_req_ready),
        .src_req       (src_req),
        .dest_req_valid(dest_req_valid),
        .dest_req_ready(dest_req_ready),
        .dest_req      (dest_req)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t mk_req(input logic [31:0] addr);
        mem_req_t r;
        r.req_addr  = addr;
        r.req_wdata = $urandom;
        r.req_be    = 4'($urandom);
        r.req_we    = 1'($urandom);
        return r;
    endfunction

    // One clock cycle. Outputs are compared against the model on the falling
    // edge, the model is advanced on the rising edge, and the task returns
    // 1 ns after the rising edge.
    task automatic cycle(input string tag);
        bit       exp_ready;
        bit       exp_valid;
        mem_req_t exp_req;
        bit       do_push;
        bit       do_pop;
        @(negedge src_clk);
        exp_ready = model_live && (model_q.size() < DEPTH);
        exp_valid = (model_q.size() != 0);
        exp_req   = exp_valid ? model_q[0] : '0;
        check({tag, ".ready"}, 128'(src_req_ready), 128'(exp_ready));
        check({tag, ".valid"}, 128'(dest_req_valid), 128'(exp_valid));
        check({tag, ".req"}, 128'(dest_req), 128'(exp_req));
        do_push = src_req_valid && exp_ready;
        do_pop  = exp_valid && dest_req_ready;
        @(posedge src_clk);
        if (do_pop) void'(model_q.pop_front());
        if (do_push) model_q.push_back(src_req);
        last_push = do_push;
        #1;
    endtask

    initial begin
        src_rstn       = 1'b0;
        src_req_valid  = 1'b0;
        dest_req_ready = 1'b0;
        src_req        = '0;
        model_live     = 0;

        // Outputs while reset is held
        #2;
        check("rst.ready", 128'(src_req_ready), 128'(0));
        check("rst.valid", 128'(dest_req_valid), 128'(0));
        check("rst.req", 128'(dest_req), 128'(0));

        // Release reset between edges; the first edge after that makes the
        // block ready.
        #10 src_rstn = 1'b1;
        @(posedge src_clk);
        #1;
        model_live = 1;
        check("rst_rel.ready", 128'(src_req_ready), 128'(1));
        check("rst_rel.valid", 128'(dest_req_valid), 128'(0));

        // Stream 0x1..0xF with dest always ready
        dest_req_ready = 1'b1;
        for (int a = 1; a <= 15; a++) begin
            src_req       = mk_req(32'(a));
            src_req_valid = 1'b1;
            cycle("stream");
        end
        src_req_valid = 1'b0;
        src_req       = mk_req(32'hdead);
        for (int i = 0; i < 2; i++) cycle("stream_tail");

        // Fill with 0xA..0xD while dest is stalled
        dest_req_ready = 1'b0;
        for (int a = 10; a <= 13; a++) begin
            src_req       = mk_req(32'(a));
            src_req_valid = 1'b1;
            cycle("fill");
        end
        check("fill.full_ready", 128'(src_req_ready), 128'(0));
        src_req = mk_req(32'hE);
        for (int i = 0; i < 3; i++) cycle("fill_hold");
        check("fill.size", 128'(model_q.size()), 128'(DEPTH));

        // Drain; 0xE is held until it is accepted, then comes out fifth
        dest_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle("drain");
            if (last_push) src_req_valid = 1'b0;
        end
        check("drain.e_taken", 128'(src_req_valid), 128'(0));
        check("drain.empty", 128'(dest_req_valid), 128'(0));

        // Concurrent: reach occupancy 2, then push and pop in the same cycle
        dest_req_ready = 1'b0;
        for (int a = 32; a < 34; a++) begin
            src_req = mk_req(32'(a)); src_req_valid = 1'b1; cycle("conc_setup");
        end
        dest_req_ready = 1'b1;
        for (int a = 34; a < 40; a++) begin
            src_req = mk_req(32'(a)); cycle("conc");
            check("conc.size", 128'(model_q.size()), 128'(2));
        end
        src_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("conc_drain");

        // Reset mid-operation with three entries stored
        dest_req_ready = 1'b0;
        for (int a = 64; a < 67; a++) begin
            src_req = mk_req(32'(a)); src_req_valid = 1'b1; cycle("mrst_setup");
        end
        src_req_valid = 1'b0;
        #2 src_rstn = 1'b0;
        #1;
        check("mrst.valid", 128'(dest_req_valid), 128'(0));
        check("mrst.req", 128'(dest_req), 128'(0));
        check("mrst.ready", 128'(src_req_ready), 128'(0));
        model_q.delete();
        model_live = 0;
        @(negedge src_clk);
        #2 src_rstn = 1'b1;
        @(posedge src_clk);
        #1;
        model_live = 1;
        dest_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) cycle("mrst_after");

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            src_req_valid  = 1'($urandom_range(0, 1));
            dest_req_ready = ($urandom_range(0, 3) != 0);
            src_req        = mk_req($urandom);
            cycle("rand");
        end
        src_req_valid  = 1'b0;
        dest_req_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle("rand_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
